branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the pipelined RV32I core.
- Sits upstream of the EX-stage branch comparator.
  - IF-stage lookup: from the fetch PC, supplies the predicted direction. This value travels down the pipeline as the comparator's fallback select.
  - EX-stage update: consumes the resolved branch outcome.
- Direct-mapped BTB of tagged entries. Each entry holds a target and a 2-bit saturating counter.
- Also generates the mispredict flush and the redirect PC.

Parameters:
- IDX_W, 6, index bits; table depth = 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- TAG_W, 8, tag bits taken from pc[IDX_W+TAG_W+1:IDX_W+2].

Ports:
- clk_i  in  1  sole clock.
- rst_ni  in  1  asynchronous active-low reset.
- pc_i  in  32  IF-stage fetch PC.
- pred_taken_o  out  1  predicted taken for pc_i.
- pred_target_o  out  32  predicted next PC for pc_i.
- upd_valid_i  in  1  EX-stage instruction valid (not flushed or stalled).
- upd_op_i  in  8  {funct3, opcode[6:2]} of the EX instruction; a branch when [4:0]==5'b11000.
- upd_pc_i  in  32  PC of the EX instruction.
- upd_taken_i  in  1  resolved direction (comparator select output).
- upd_target_i  in  32  computed branch target.
- upd_pred_taken_i  in  1  prediction carried down the pipe with this instruction.
- upd_pred_target_i  in  32  predicted target carried down the pipe.
- flush_o  out  1  mispredict: kill IF/ID and redirect.
- redirect_pc_o  out  32  correct next PC when flush_o=1.

Behaviour:
- State per entry: valid (1b), tag (TAG_W), target (32b), ctr (2b).
  - ctr encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.
- Reset (rst_ni=0, async):
  - All entries: valid=0, ctr=01, tag=0, target=0.
  - Outputs fall out of the combinational logic:
    - pred_taken_o=0.
    - pred_target_o=pc_i+4.
    - flush_o=0.
    - redirect_pc_o=upd_pc_i+4.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==pc tag.
  - pred_taken_o = hit && ctr[1].
  - pred_target_o = pred_taken_o ? target[idx] : pc_i+4.
- Update (clocked, rising edge): upd_en = upd_valid_i && upd_op_i[4:0]==5'b11000.
  - upd_en=0: table unchanged.
  - Hit, taken: ctr saturating +1 (11 stays 11); target <= upd_target_i.
  - Hit, not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - Miss, taken: allocate / overwrite the entry: valid=1, tag, target=upd_target_i, ctr=10.
  - Miss, not taken: no allocation.
- Read-before-write:
  - A lookup and an update to the same index in the same cycle return the pre-update entry.
  - The new value is visible the next cycle.
- Mispredict (combinational from the update port, gated by upd_en):
  - flush_o = (upd_taken_i != upd_pred_taken_i) || (upd_taken_i && upd_target_i != upd_pred_target_i).
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4.
- Non-branch instructions never flush.
  - JAL/JALR are outside this block; their redirect is handled elsewhere.
- Aliasing:
  - A tag mismatch on update counts as a miss.
  - A taken miss evicts the current occupant unconditionally.
- PC arithmetic is 32-bit wrap-around: 0xFFFFFFFC+4 = 0x00000000.
- Reset mid-operation clears the table immediately; no pending state survives.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds ports stat_branches_o (32) and stat_mispred_o (32).
  - Both are free-running wrap-around counters, reset to 0.
  - stat_branches_o increments on every upd_en.
  - stat_mispred_o increments on every cycle with flush_o=1.
- Undefined: ports and counters are absent; prediction behaviour is identical.

Decomposition:
- Package bp_pkg:
  - ctr_t enum (SNT, WNT, WT, ST).
  - OPC_BRANCH = 5'b11000.
  - CTR_RESET = WNT.
  - CTR_ALLOC = WT.
  - bp_entry_t struct (valid, tag, target, ctr).
- Sub-module bp_sat_ctr: combinational 2-bit saturating next-state function (ctr_i, taken_i -> ctr_o).

Test Plan:
1. After reset, pc_i=0x100 -> pred_taken_o=0, pred_target_o=0x104; then update 0x100 taken->0x80 with pred 0 -> flush_o=1, redirect_pc_o=0x80; next cycle lookup 0x100 -> taken, target 0x80 (ctr=10).
2. Train 0x200 taken three times (ctr 10->11->11), then not taken once -> lookup still taken (ctr 10); second not-taken -> pred_taken_o=0 (ctr 01).
3. Update 0x300 not taken with no entry -> no allocation; lookup 0x300 -> miss, pred_target_o=0x304; flush_o=0 when upd_pred_taken_i=0.
4. Alias: allocate 0x100, then taken update of 0x100+(1<<(IDX_W+2)) -> lookup 0x100 misses; same-cycle lookup+update on one index returns the old entry.
5. Hit with correct direction but wrong target (pred 0x80, actual 0x90) -> flush_o=1, redirect 0x90; upd_op_i=0x0C (not a branch) with mismatches -> flush_o=0, table unchanged.
6. Assert rst_ni mid-stream after training -> all lookups miss immediately; with BP_STATS_EN, after cases 1-2 the counters read the exact update and flush counts, and 0 after reset.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB branch predictor.
// Counter encoding, branch opcode match and the BTB entry layout.
package bp_pkg;

  localparam int BP_IDX_W = 6;
  localparam int BP_TAG_W = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam ctr_t       CTR_RESET  = WNT;
  localparam ctr_t       CTR_ALLOC  = WT;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    ctr_t                ctr;
  } bp_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup and update bus between the pipeline and the predictor.
// slave = predictor side, master = pipeline side.
interface branch_predictor_if;
  logic [31:0] pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [7:0]  upd_op_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        flush_o;
  logic [31:0] redirect_pc_o;

  modport slave (
    input  pc_i, upd_valid_i, upd_op_i, upd_pc_i,
    input  upd_taken_i, upd_target_i,
    input  upd_pred_taken_i, upd_pred_target_i,
    output pred_taken_o, pred_target_o,
    output flush_o, redirect_pc_o
  );

  modport master (
    output pc_i, upd_valid_i, upd_op_i, upd_pc_i,
    output upd_taken_i, upd_target_i,
    output upd_pred_taken_i, upd_pred_target_i,
    input  pred_taken_o, pred_target_o,
    input  flush_o, redirect_pc_o
  );
endinterface

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state function.
// Moves toward ST on taken, toward SNT on not taken.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t ctr_o
);

  // Saturate at both ends of the range.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_t'(ctr_i + 2'd1);
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_t'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor with mispredict flush/redirect.
// Optional BP_STATS_EN adds branch and mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W,
  parameter int TAG_W = BP_TAG_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  branch_predictor_if.slave bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispred_o
`endif
);

  localparam int DEPTH = 2 ** IDX_W;

  bp_entry_t tbl_q [DEPTH];
  bp_entry_t l_ent;
  bp_entry_t u_ent;
  bp_entry_t ent_d;

  logic [IDX_W-1:0] l_idx;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] l_tag;
  logic [TAG_W-1:0] u_tag;
  logic             l_hit;
  logic             u_hit;
  logic             upd_en;
  logic             wr_en;
  logic             flush;
  ctr_t             ctr_nxt;
  logic             unused_bits;

  assign l_idx = bus.pc_i[IDX_W+1:2];
  assign l_tag = bus.pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = bus.upd_pc_i[IDX_W+1:2];
  assign u_tag = bus.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  assign unused_bits = ^{bus.pc_i[1:0],
                         bus.pc_i[31:IDX_W+TAG_W+2],
                         bus.upd_op_i[7:5]};

  // Lookup reads the pre-update entry.
  always_comb begin
    l_ent = tbl_q[l_idx];
    l_hit = l_ent.valid && (l_ent.tag == l_tag);
    bus.pred_taken_o  = l_hit && l_ent.ctr[1];
    bus.pred_target_o = bus.pred_taken_o ? l_ent.target
                                         : bus.pc_i + 32'd4;
  end

  bp_sat_ctr u_ctr (
    .ctr_i   (u_ent.ctr),
    .taken_i (bus.upd_taken_i),
    .ctr_o   (ctr_nxt)
  );

  // Train on hit, allocate only on a taken miss.
  always_comb begin
    upd_en = bus.upd_valid_i && (bus.upd_op_i[4:0] == OPC_BRANCH);
    u_ent  = tbl_q[u_idx];
    u_hit  = u_ent.valid && (u_ent.tag == u_tag);
    wr_en  = 1'b0;
    ent_d  = u_ent;
    if (upd_en) begin
      if (u_hit) begin
        wr_en     = 1'b1;
        ent_d.ctr = ctr_nxt;
        if (bus.upd_taken_i) ent_d.target = bus.upd_target_i;
      end else if (bus.upd_taken_i) begin
        wr_en = 1'b1;
        ent_d = '{valid: 1'b1, tag: u_tag,
                  target: bus.upd_target_i, ctr: CTR_ALLOC};
      end
    end
  end

  // Mispredict detect and correct next PC.
  always_comb begin
    flush = upd_en &&
            ((bus.upd_taken_i != bus.upd_pred_taken_i) ||
             (bus.upd_taken_i &&
              (bus.upd_target_i != bus.upd_pred_target_i)));
    bus.flush_o       = flush;
    bus.redirect_pc_o = bus.upd_taken_i ? bus.upd_target_i
                                        : bus.upd_pc_i + 32'd4;
  end

  // Table storage, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0,
                      target: '0, ctr: CTR_RESET};
      end
    end else if (wr_en) begin
      tbl_q[u_idx] <= ent_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mp_cnt_q;

  // Free-running branch and mispredict counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (upd_en) br_cnt_q <= br_cnt_q + 32'd1;
      if (flush)  mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign stat_branches_o = br_cnt_q;
  assign stat_mispred_o  = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor.
// One vector per cycle; outputs checked before the commit edge.
module tb_branch_predictor;

  logic clk;
  logic rst_n;

  branch_predictor_if bus ();

`ifdef BP_STATS_EN
  logic [31:0] stat_br;
  logic [31:0] stat_mp;
`endif

  branch_predictor dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
`ifdef BP_STATS_EN
    ,
    .stat_branches_o (stat_br),
    .stat_mispred_o  (stat_mp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [7:0]  op;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        ept;
    logic [31:0] etgt;
    logic        efl;
    logic [31:0] erd;
  } vec_t;

  localparam logic [7:0] BR = 8'h18;
  localparam logic [7:0] NB = 8'h0C;

  int n_chk;
  int n_fail;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic [31:0] pc, logic uv, logic [7:0] op, logic [31:0] upc,
    logic ut, logic [31:0] utgt, logic upt, logic [31:0] uptgt,
    logic ept, logic [31:0] etgt, logic efl, logic [31:0] erd);
    vec_t v;
    v.pc = pc; v.uv = uv; v.op = op; v.upc = upc;
    v.ut = ut; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
    v.ept = ept; v.etgt = etgt; v.efl = efl; v.erd = erd;
    return v;
  endfunction

  function automatic vec_t idle(logic [31:0] pc, logic ept,
                                logic [31:0] etgt);
    return mk(pc, 0, 8'h00, 0, 0, 0, 0, 0, ept, etgt, 0, 32'h4);
  endfunction

  task automatic drive(input vec_t v);
    bus.pc_i              = v.pc;
    bus.upd_valid_i       = v.uv;
    bus.upd_op_i          = v.op;
    bus.upd_pc_i          = v.upc;
    bus.upd_taken_i       = v.ut;
    bus.upd_target_i      = v.utgt;
    bus.upd_pred_taken_i  = v.upt;
    bus.upd_pred_target_i = v.uptgt;
  endtask

  task automatic check_vec(input string tg, input vec_t v);
    chk({tg, ".pred_taken"}, 32'(bus.pred_taken_o), 32'(v.ept));
    chk({tg, ".pred_target"}, bus.pred_target_o, v.etgt);
    chk({tg, ".flush"}, 32'(bus.flush_o), 32'(v.efl));
    chk({tg, ".redirect"}, bus.redirect_pc_o, v.erd);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(mk(32'h100, 0, 8'h00, 32'h20, 0, 0, 0, 0,
             0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #1;
    check_vec("reset", mk(0, 0, 0, 0, 0, 0, 0, 0,
                          0, 32'h104, 0, 32'h24));
`ifdef BP_STATS_EN
    chk("reset.stat_br", stat_br, 0);
    chk("reset.stat_mp", stat_mp, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // case 1: first taken allocates WT
    vq.push_back(idle(32'h100, 0, 32'h104));
    vq.push_back(mk(32'h100, 1, BR, 32'h100, 1, 32'h80, 0, 32'h104,
                    0, 32'h104, 1, 32'h80));
    vq.push_back(idle(32'h100, 1, 32'h80));
    // case 2: 0x200 aliases index 0, evicts 0x100
    vq.push_back(mk(32'h200, 1, BR, 32'h200, 1, 32'h240, 0, 32'h204,
                    0, 32'h204, 1, 32'h240));
    vq.push_back(mk(32'h200, 1, BR, 32'h200, 1, 32'h240, 1, 32'h240,
                    1, 32'h240, 0, 32'h240));
    vq.push_back(mk(32'h200, 1, BR, 32'h200, 1, 32'h240, 1, 32'h240,
                    1, 32'h240, 0, 32'h240));
    vq.push_back(mk(32'h200, 1, BR, 32'h200, 0, 32'h240, 1, 32'h240,
                    1, 32'h240, 1, 32'h204));
    vq.push_back(idle(32'h200, 1, 32'h240));
    vq.push_back(mk(32'h200, 1, BR, 32'h200, 0, 32'h240, 1, 32'h240,
                    1, 32'h240, 1, 32'h204));
    vq.push_back(idle(32'h200, 0, 32'h204));
    // case 3: not-taken miss does not allocate
    vq.push_back(mk(32'h300, 1, BR, 32'h300, 0, 32'h380, 0, 32'h304,
                    0, 32'h304, 0, 32'h304));
    vq.push_back(idle(32'h300, 0, 32'h304));
    // case 4: eviction and read-before-write
    vq.push_back(mk(32'h100, 1, BR, 32'h100, 1, 32'h80, 0, 32'h104,
                    0, 32'h104, 1, 32'h80));
    vq.push_back(mk(32'h100, 1, BR, 32'h200, 1, 32'h240, 0, 32'h204,
                    1, 32'h80, 1, 32'h240));
    vq.push_back(idle(32'h100, 0, 32'h104));
    vq.push_back(idle(32'h200, 1, 32'h240));
    // case 5: wrong target on a hit, then non-branch
    vq.push_back(mk(32'h104, 1, BR, 32'h104, 1, 32'h80, 0, 32'h108,
                    0, 32'h108, 1, 32'h80));
    vq.push_back(mk(32'h104, 1, BR, 32'h104, 1, 32'h90, 1, 32'h80,
                    1, 32'h80, 1, 32'h90));
    vq.push_back(idle(32'h104, 1, 32'h90));
    vq.push_back(mk(32'h104, 1, NB, 32'h104, 1, 32'h500, 0, 32'h77,
                    1, 32'h90, 0, 32'h500));
    vq.push_back(idle(32'h104, 1, 32'h90));
    vq.push_back(mk(32'h104, 0, BR, 32'h104, 1, 32'h600, 0, 32'h0,
                    1, 32'h90, 0, 32'h600));
    vq.push_back(idle(32'h104, 1, 32'h90));
    // wrap-around PC arithmetic
    vq.push_back(mk(32'hFFFFFFFC, 1, BR, 32'hFFFFFFFC, 0, 32'h10,
                    0, 32'h0, 0, 32'h0, 0, 32'h0));
    vq.push_back(idle(32'hFFFFFFFC, 0, 32'h0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      #1;
      check_vec($sformatf("v%0d", i), vq[i]);
      @(negedge clk);
    end

`ifdef BP_STATS_EN
    chk("stat_br", stat_br, 12);
    chk("stat_mp", stat_mp, 8);
`endif

    // case 6: async reset mid-stream clears the table at once
    drive(idle(32'h104, 1, 32'h90));
    #1;
    chk("pre_rst.pred_taken", 32'(bus.pred_taken_o), 1);
    rst_n = 1'b0;
    #1;
    chk("rst.pred_taken", 32'(bus.pred_taken_o), 0);
    chk("rst.pred_target", bus.pred_target_o, 32'h108);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle(32'h200, 0, 32'h204));
    #1;
    chk("post_rst.200.taken", 32'(bus.pred_taken_o), 0);
    chk("post_rst.200.target", bus.pred_target_o, 32'h204);
`ifdef BP_STATS_EN
    chk("post_rst.stat_br", stat_br, 0);
    chk("post_rst.stat_mp", stat_mp, 0);
`endif
    drive(mk(32'h104, 1, BR, 32'h104, 1, 32'hA0, 0, 32'h108,
             0, 32'h108, 1, 32'hA0));
    #1;
    check_vec("post_rst.alloc", mk(0, 0, 0, 0, 0, 0, 0, 0,
                                   0, 32'h108, 1, 32'hA0));
    @(negedge clk);
    drive(idle(32'h104, 1, 32'hA0));
    #1;
    check_vec("post_rst.hit", idle(0, 1, 32'hA0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
